cle_pin_serializer: RTL
=======================

Name: cle_pin_serializer

Overview:
- Pin-reduction front end inside the CLE top level.
- Accepts parallel ROM-read, SRAM-read and SRAM-write commands from the labeling core.
- Serializes each address or write data onto 1-bit pins (rom_a_o, sram_a_o, sram_d_o), MSB first, and tags every bit cycle with a 2-bit frame type on dtype_o.
- Captures the parallel read data returned by the external ROM/SRAM and hands it back to the core as a one-cycle response.

Parameters:
- ROM_AW, 7: ROM address width; ROM address frame length in cycles.
- SRAM_AW, 10: SRAM address width; SRAM address frame length in cycles.
- DW, 8: write-data width; data frame length in cycles.
- SQ_W, 7: width of the SRAM read-data pins.
- RD_LAT, 2: idle cycles (minimum 1) between the end of an address frame and read-data capture.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; command accepted on a clk edge where cmd_valid&&cmd_ready
- cmd_type  in  2  0=ROM read, 1=SRAM read, 2=SRAM write, 3=illegal
- cmd_addr  in  SRAM_AW  address; ROM commands use bits [ROM_AW-1:0]
- cmd_wdata  in  DW  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_data  out  DW  read data; 0 for writes; 8'hFF for illegal commands
- rom_q_i  in  8  ROM parallel read data
- sram_q_i  in  SQ_W  SRAM parallel read data
- rom_a_o  out  1  serial ROM address bit
- sram_a_o  out  1  serial SRAM address bit
- sram_d_o  out  1  serial SRAM write-data bit
- sram_wen_o  out  1  SRAM write enable, active low
- dtype_o  out  2  frame type: 0=idle, 1=ROM addr, 2=SRAM addr, 3=SRAM data

Behaviour:
- Reset values:
  - state=IDLE; cmd_ready=1.
  - rsp_valid=0; rsp_data=0.
  - rom_a_o, sram_a_o, sram_d_o = 0; dtype_o=0; sram_wen_o=1.
- All outputs are registered; cmd_ready is decoded from state==IDLE.
- Command fields are latched at acceptance. Edge of acceptance = E0; cycle k is the cycle following Ek.
- Only the serial pin of the active frame toggles. The other serial pins hold 0. In every cycle where dtype_o=0, all serial pins are 0.
- States: IDLE, ROM_ADDR, SRAM_ADDR, SRAM_DATA, WRITE, WAIT, RESP.
- ROM read:
  - Cycles 0..6: ROM_ADDR, dtype_o=1, rom_a_o=addr[6-k].
  - Then WAIT for RD_LAT cycles with dtype_o=0.
  - At E(7+RD_LAT): capture rom_q_i into rsp_data and enter RESP (rsp_valid=1 for one cycle).
  - Next edge: IDLE.
- SRAM read:
  - Cycles 0..9: SRAM_ADDR, dtype_o=2, sram_a_o=addr[9-k].
  - Then WAIT for RD_LAT cycles.
  - At E(10+RD_LAT): rsp_data={1'b0,sram_q_i} (zero-extended); RESP.
- SRAM write:
  - Cycles 0..9: SRAM_ADDR frame.
  - Cycles 10..17: SRAM_DATA, dtype_o=3, sram_d_o=wdata[7-(k-10)].
  - Cycle 18: WRITE, dtype_o=0, sram_wen_o=0. This is the only cycle with wen low.
  - E19: RESP with rsp_data=0. E20: IDLE.
- Illegal type 3: accepted, no pin activity; RESP at E1 with rsp_data=8'hFF.
- A bit counter is loaded at each frame start and counts down. A frame always completes its full length; there are no partial frames.
- cmd_valid while busy is ignored; the command is not queued and the core holds it until cmd_ready.
- Back-to-back commands: in the IDLE cycle after RESP, cmd_ready=1 and a new command can be accepted at that edge. Minimum command spacing is therefore one IDLE cycle.
- rsp_data holds its value until the next RESP.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). No response is issued for the aborted command. sram_wen_o is forced to 1 even when reset arrives in WRITE.

Optional Feature:
- Macro: CLE_SER_GUARD_EN.
- When defined:
  - One guard cycle (dtype_o=0, serial pins 0) is inserted after every address frame and after every data frame.
  - Latencies: ROM read RESP at E(8+RD_LAT); SRAM read RESP at E(11+RD_LAT).
  - Write: data frame in cycles 11..18, guard in cycle 19, wen low in cycle 20, RESP at E21.
- When undefined: timing exactly as in Behaviour.

Test Plan (RD_LAT=2, guard disabled):
- ROM read, addr 7'h55, rom_q_i=8'hA3 -> dtype_o=1 for 7 cycles, rom_a_o=1,0,1,0,1,0,1; rsp_valid high only in the cycle after E9, rsp_data=8'hA3; cmd_ready=0 from E0 to E10.
- SRAM write, addr 10'h3FF, wdata 8'h5A -> dtype_o=2 for 10 cycles with sram_a_o all 1; dtype_o=3 for 8 cycles with sram_d_o=0,1,0,1,1,0,1,0; sram_wen_o=0 only in cycle 18; rsp_valid at E19 with data 0.
- SRAM read, addr 10'h201, sram_q_i=7'h12 -> sram_a_o=1,0,0,0,0,0,0,0,0,1; rsp_data=8'h12 at E12.
- Reset asserted during cycle 12 of a write -> all outputs at reset values within the same cycle; sram_wen_o never goes low; no rsp_valid; cmd_ready=1 after reset release.
- cmd_valid held high with ROM read, then SRAM read queued behind it -> second command accepted exactly at E11 (the IDLE cycle); no overlap of dtype frames; two rsp_valid pulses.
- cmd_type=3 -> dtype_o stays 0; rsp_valid at E1 with rsp_data=8'hFF.

Source files
------------

// File: rtl/cle_pin_serializer.sv
//------------------------------------------------------------------------------
// cle_pin_serializer
//
// Pin-reduction front end of the CLE top level. Parallel ROM-read, SRAM-read
// and SRAM-write commands from the labeling core are serialized MSB first onto
// 1-bit pins. Every bit cycle is tagged with a frame type on dtype_o. Parallel
// read data returned by the external memories is captured and handed back to
// the core as a one-cycle response.
//
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   cmd_valid    : command request from the core
//   cmd_ready    : high only while idle; accept on cmd_valid && cmd_ready
//   cmd_type     : 0=ROM read, 1=SRAM read, 2=SRAM write, 3=illegal
//   cmd_addr     : address (ROM commands use the low ROM_AW bits)
//   cmd_wdata    : SRAM write data
//   rsp_valid    : one-cycle response pulse
//   rsp_data     : read data; 0 for writes, all ones for illegal commands
//   rom_q_i      : ROM parallel read data
//   sram_q_i     : SRAM parallel read data
//   rom_a_o      : serial ROM address
//   sram_a_o     : serial SRAM address
//   sram_d_o     : serial SRAM write data
//   sram_wen_o   : SRAM write enable, active low
//   dtype_o      : frame type 0=idle, 1=ROM addr, 2=SRAM addr, 3=SRAM data
//
// Build option:
//   CLE_SER_GUARD_EN : when defined, one idle guard cycle follows every
//                      address frame and every data frame.
//------------------------------------------------------------------------------
module cle_pin_serializer #(
    parameter int ROM_AW  = 7,
    parameter int SRAM_AW = 10,
    parameter int DW      = 8,
    parameter int SQ_W    = 7,
    parameter int RD_LAT  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_type,
    input  logic [SRAM_AW-1:0] cmd_addr,
    input  logic [DW-1:0]      cmd_wdata,
    output logic               rsp_valid,
    output logic [DW-1:0]      rsp_data,
    input  logic [7:0]         rom_q_i,
    input  logic [SQ_W-1:0]    sram_q_i,
    output logic               rom_a_o,
    output logic               sram_a_o,
    output logic               sram_d_o,
    output logic               sram_wen_o,
    output logic [1:0]         dtype_o
);

    // Shift register is wide enough for the longest frame; every frame is
    // loaded MSB-aligned so the next bit is always taken from the top.
    localparam int MAX_AB = (SRAM_AW > ROM_AW) ? SRAM_AW : ROM_AW;
    localparam int SR_W   = (MAX_AB > DW) ? MAX_AB : DW;
    localparam int MAXL   = (SR_W > RD_LAT) ? SR_W : RD_LAT;
    localparam int CNT_W  = $clog2(MAXL + 1);

    localparam logic [CNT_W-1:0] ROM_LAST  = CNT_W'(ROM_AW - 1);
    localparam logic [CNT_W-1:0] SRAM_LAST = CNT_W'(SRAM_AW - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DW - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RD_LAT - 1);

    localparam logic [1:0] T_ROM = 2'd0;
    localparam logic [1:0] T_SRD = 2'd1;
    localparam logic [1:0] T_SWR = 2'd2;

    localparam logic [1:0] DT_IDLE = 2'd0;
    localparam logic [1:0] DT_RA   = 2'd1;
    localparam logic [1:0] DT_SA   = 2'd2;
    localparam logic [1:0] DT_SD   = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ROM_ADDR,
        S_SRAM_ADDR,
        S_SRAM_DATA,
        S_WRITE,
        S_WAIT,
        S_RESP,
        S_GUARD_A,
        S_GUARD_D
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [SR_W-1:0]  r_sh;
    logic [1:0]       r_type;
    logic [DW-1:0]    r_wdata;
    logic             r_rom_a;
    logic             r_sram_a;
    logic             r_sram_d;
    logic             r_wen;
    logic [1:0]       r_dtype;
    logic             r_rsp_valid;
    logic [DW-1:0]    r_rsp_data;

    state_t           w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [SR_W-1:0]  w_sh_next;
    logic [1:0]       w_type_next;
    logic [DW-1:0]    w_wdata_next;
    logic             w_bit;
    logic             w_rom_a_next;
    logic             w_sram_a_next;
    logic             w_sram_d_next;
    logic             w_wen_next;
    logic [1:0]       w_dtype_next;
    logic             w_rsp_valid_next;
    logic [DW-1:0]    w_rsp_data_next;

    logic [SR_W-1:0]  w_rom_al;
    logic [SR_W-1:0]  w_sram_al;
    logic [SR_W-1:0]  w_dat_al;

    assign w_rom_al  = SR_W'(cmd_addr[ROM_AW-1:0]) << (SR_W - ROM_AW);
    assign w_sram_al = SR_W'(cmd_addr) << (SR_W - SRAM_AW);
    assign w_dat_al  = SR_W'(r_wdata) << (SR_W - DW);

    //--------------------------------------------------------------------------
    // Next-state logic. The pin values are computed for the cycle that the
    // next state represents, then registered, so every output is a flop.
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_sh_next       = r_sh;
        w_type_next     = r_type;
        w_wdata_next    = r_wdata;
        w_bit           = 1'b0;
        w_rsp_data_next = r_rsp_data;

        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_type_next  = cmd_type;
                    w_wdata_next = cmd_wdata;
                    case (cmd_type)
                        T_ROM: begin
                            w_state_next = S_ROM_ADDR;
                            w_cnt_next   = ROM_LAST;
                            w_bit        = w_rom_al[SR_W-1];
                            w_sh_next    = w_rom_al << 1;
                        end
                        T_SRD, T_SWR: begin
                            w_state_next = S_SRAM_ADDR;
                            w_cnt_next   = SRAM_LAST;
                            w_bit        = w_sram_al[SR_W-1];
                            w_sh_next    = w_sram_al << 1;
                        end
                        default: begin
                            // Illegal command: one silent cycle, then respond.
                            w_state_next = S_WAIT;
                            w_cnt_next   = '0;
                        end
                    endcase
                end
            end

            S_ROM_ADDR, S_SRAM_ADDR, S_SRAM_DATA: begin
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - 1'b1;
                    w_bit      = r_sh[SR_W-1];
                    w_sh_next  = r_sh << 1;
                end else if (r_state == S_SRAM_DATA) begin
`ifdef CLE_SER_GUARD_EN
                    w_state_next = S_GUARD_D;
`else
                    w_state_next = S_WRITE;
`endif
                end else begin
`ifdef CLE_SER_GUARD_EN
                    w_state_next = S_GUARD_A;
`else
                    if (r_type == T_SWR) begin
                        w_state_next = S_SRAM_DATA;
                        w_cnt_next   = DATA_LAST;
                        w_bit        = w_dat_al[SR_W-1];
                        w_sh_next    = w_dat_al << 1;
                    end else begin
                        w_state_next = S_WAIT;
                        w_cnt_next   = WAIT_LAST;
                    end
`endif
                end
            end

`ifdef CLE_SER_GUARD_EN
            S_GUARD_A: begin
                if (r_type == T_SWR) begin
                    w_state_next = S_SRAM_DATA;
                    w_cnt_next   = DATA_LAST;
                    w_bit        = w_dat_al[SR_W-1];
                    w_sh_next    = w_dat_al << 1;
                end else begin
                    w_state_next = S_WAIT;
                    w_cnt_next   = WAIT_LAST;
                end
            end

            S_GUARD_D: begin
                w_state_next = S_WRITE;
            end
`endif

            S_WAIT: begin
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - 1'b1;
                end else begin
                    // Read data is sampled on the edge that enters RESP.
                    w_state_next = S_RESP;
                    case (r_type)
                        T_ROM:   w_rsp_data_next = DW'(rom_q_i);
                        T_SRD:   w_rsp_data_next = DW'(sram_q_i);
                        default: w_rsp_data_next = '1;
                    endcase
                end
            end

            S_WRITE: begin
                w_state_next    = S_RESP;
                w_rsp_data_next = '0;
            end

            S_RESP: begin
                w_state_next = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state: only the active frame's pin carries
    // data, everything else is held at its idle level.
    always_comb begin
        w_rom_a_next     = 1'b0;
        w_sram_a_next    = 1'b0;
        w_sram_d_next    = 1'b0;
        w_wen_next       = 1'b1;
        w_dtype_next     = DT_IDLE;
        w_rsp_valid_next = 1'b0;
        case (w_state_next)
            S_ROM_ADDR: begin
                w_dtype_next = DT_RA;
                w_rom_a_next = w_bit;
            end
            S_SRAM_ADDR: begin
                w_dtype_next  = DT_SA;
                w_sram_a_next = w_bit;
            end
            S_SRAM_DATA: begin
                w_dtype_next  = DT_SD;
                w_sram_d_next = w_bit;
            end
            S_WRITE: w_wen_next       = 1'b0;
            S_RESP:  w_rsp_valid_next = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_sh        <= '0;
            r_type      <= '0;
            r_wdata     <= '0;
            r_rom_a     <= 1'b0;
            r_sram_a    <= 1'b0;
            r_sram_d    <= 1'b0;
            r_wen       <= 1'b1;
            r_dtype     <= DT_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_sh        <= w_sh_next;
            r_type      <= w_type_next;
            r_wdata     <= w_wdata_next;
            r_rom_a     <= w_rom_a_next;
            r_sram_a    <= w_sram_a_next;
            r_sram_d    <= w_sram_d_next;
            r_wen       <= w_wen_next;
            r_dtype     <= w_dtype_next;
            r_rsp_valid <= w_rsp_valid_next;
            r_rsp_data  <= w_rsp_data_next;
        end
    end

    assign cmd_ready  = (r_state == S_IDLE);
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rom_a_o    = r_rom_a;
    assign sram_a_o   = r_sram_a;
    assign sram_d_o   = r_sram_d;
    assign sram_wen_o = r_wen;
    assign dtype_o    = r_dtype;

endmodule
